// File: rtl/snoopy_bus_ctrl_if.sv
// rtl/snoopy_bus_ctrl_if.sv - SystemBus cache-port, invalidate and memory-port signal bundle
interface snoopy_bus_ctrl_if #(
   parameter int NPORT      = 2,
   parameter int WIDTH      = 128,
   parameter int MASKW      = WIDTH / 8,
   parameter int ADDR_WIDTH = 32
);
   logic [NPORT-1:0]            rw_valid;
   logic [NPORT-1:0]            rw_ready;
   logic [NPORT*ADDR_WIDTH-1:0] rw_addr;
   logic [NPORT-1:0]            rw_we;
   logic [NPORT*MASKW-1:0]      w_mask;
   logic [NPORT*WIDTH-1:0]      w_data;
   logic [NPORT-1:0]            w_ce;
   logic [WIDTH-1:0]            r_data;
   logic [NPORT-1:0]            inv_valid;
   logic [ADDR_WIDTH-1:0]       inv_addr;
   logic [NPORT-1:0]            inv_ready;
   logic                        mem_valid;
   logic                        mem_ready;
   logic [ADDR_WIDTH-1:0]       mem_addr;
   logic                        mem_we;
   logic [MASKW-1:0]            mem_wmask;
   logic [WIDTH-1:0]            mem_wdata;
   logic                        mem_ce;
   logic [WIDTH-1:0]            mem_rdata;

   modport slave (
      input  rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
             mem_ready, mem_rdata,
      output rw_ready, r_data, inv_valid, inv_addr,
             mem_valid, mem_addr, mem_we, mem_wmask, mem_wdata, mem_ce
   );

   modport master (
      output rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
             mem_ready, mem_rdata,
      input  rw_ready, r_data, inv_valid, inv_addr,
             mem_valid, mem_addr, mem_we, mem_wmask, mem_wdata, mem_ce
   );
endinterface

// File: rtl/snoopy_bus_ctrl.sv
// rtl/snoopy_bus_ctrl.sv - SystemBus responder: one-at-a-time memory forwarding with posted snoop invalidates
// Define SYSBUS_RR_ARB_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module snoopy_bus_ctrl #(
   parameter int NPORT      = 2,
   parameter int WIDTH      = 128,
   parameter int MASKW      = WIDTH / 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   snoopy_bus_ctrl_if.slave  bus
);

   localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [MASKW-1:0]      mask_q, mask_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  ce_q, ce_d;
   logic [WIDTH-1:0]      rdata_q, rdata_d;
   logic [NPORT-1:0]      inv_pend_q, inv_pend_d;
   logic [ADDR_WIDTH-1:0] inv_addr_q, inv_addr_d;
   logic [NPORT-1:0]      excl_q, excl_d;
`ifdef SYSBUS_RR_ARB_EN
   logic [GW-1:0]         rr_q, rr_d;
`endif

   logic [NPORT-1:0]      elig;
   logic                  pick_vld;
   logic [GW-1:0]         pick_idx;
   logic [GW-1:0]         idx;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_we;
   logic [MASKW-1:0]      sel_mask;
   logic [WIDTH-1:0]      sel_data;
   logic                  sel_ce;

   // Writes wait for every outstanding invalidate; reads never do, or a refilling cache would deadlock.
   // The port just answered is masked for one cycle so it cannot be re-granted on a stale valid.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NPORT; i++) begin
         elig[i] = bus.rw_valid[i] && !excl_q[i] && (!bus.rw_we[i] || (inv_pend_q == '0));
      end
   end

   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = '0;
      for (int k = 0; k < NPORT; k++) begin
`ifdef SYSBUS_RR_ARB_EN
         idx = GW'((k + int'(rr_q)) % NPORT);
`else
         idx = GW'(k);
`endif
         if (!pick_vld && elig[idx]) begin
            pick_vld = 1'b1;
            pick_idx = idx;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_we   = 1'b0;
      sel_mask = '0;
      sel_data = '0;
      sel_ce   = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (pick_idx == GW'(i)) begin
            sel_addr = bus.rw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_we   = bus.rw_we[i];
            sel_mask = bus.w_mask[i*MASKW +: MASKW];
            sel_data = bus.w_data[i*WIDTH +: WIDTH];
            sel_ce   = bus.w_ce[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      we_d       = we_q;
      mask_d     = mask_q;
      data_d     = data_q;
      ce_d       = ce_q;
      rdata_d    = rdata_q;
      inv_pend_d = inv_pend_q & ~bus.inv_ready;
      inv_addr_d = inv_addr_q;
      excl_d     = '0;
`ifdef SYSBUS_RR_ARB_EN
      rr_d       = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               addr_d  = sel_addr;
               we_d    = sel_we;
               mask_d  = sel_mask;
               data_d  = sel_data;
               ce_d    = sel_ce;
               state_d = MEM;
            end
         end
         MEM: begin
            if (bus.mem_ready) begin
               rdata_d = bus.mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d         = IDLE;
            excl_d[grant_q] = 1'b1;
`ifdef SYSBUS_RR_ARB_EN
            rr_d            = GW'((int'(grant_q) + 1) % NPORT);
`endif
            // The writer is invalidated too: its read-only line did not absorb the write-through.
            if (we_q) begin
               inv_pend_d = '1;
               inv_addr_d = addr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         mask_q     <= '0;
         data_q     <= '0;
         ce_q       <= 1'b0;
         rdata_q    <= '0;
         inv_pend_q <= '0;
         inv_addr_q <= '0;
         excl_q     <= '0;
`ifdef SYSBUS_RR_ARB_EN
         rr_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         mask_q     <= mask_d;
         data_q     <= data_d;
         ce_q       <= ce_d;
         rdata_q    <= rdata_d;
         inv_pend_q <= inv_pend_d;
         inv_addr_q <= inv_addr_d;
         excl_q     <= excl_d;
`ifdef SYSBUS_RR_ARB_EN
         rr_q       <= rr_d;
`endif
      end
   end

   always_comb begin
      bus.mem_valid = (state_q == MEM);
      bus.mem_addr  = (state_q == MEM) ? addr_q : '0;
      bus.mem_we    = (state_q == MEM) && we_q;
      bus.mem_wmask = (state_q == MEM) ? mask_q : '0;
      bus.mem_wdata = (state_q == MEM) ? data_q : '0;
      bus.mem_ce    = (state_q == MEM) && ce_q;
      bus.r_data    = rdata_q;
      bus.inv_valid = inv_pend_q;
      bus.inv_addr  = inv_addr_q;
      bus.rw_ready  = '0;
      for (int i = 0; i < NPORT; i++) begin
         bus.rw_ready[i] = (state_q == RESP) && (grant_q == GW'(i));
      end
   end

endmodule

// File: tb/tb_snoopy_bus_ctrl.sv
// tb/tb_snoopy_bus_ctrl.sv - vector-table and directed-sequence bench for snoopy_bus_ctrl
module tb_snoopy_bus_ctrl;

   localparam int NPORT = 2;
   localparam int WIDTH = 128;
   localparam int MASKW = 16;
   localparam int AW    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   snoopy_bus_ctrl_if #(.NPORT(NPORT), .WIDTH(WIDTH), .MASKW(MASKW), .ADDR_WIDTH(AW)) bus ();

   snoopy_bus_ctrl #(.NPORT(NPORT), .WIDTH(WIDTH), .MASKW(MASKW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [AW-1:0]    A0 = 32'h0000_1000;
   localparam logic [AW-1:0]    A1 = 32'h0000_2000;
   localparam logic [MASKW-1:0] M0 = 16'hFFFF;
   localparam logic [MASKW-1:0] M1 = 16'h000F;
   localparam logic [WIDTH-1:0] D0 = 128'h5555_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [WIDTH-1:0] D1 = 128'hAAAA_9999_8888_7777_6666_5555_4444_3333;

   typedef struct {
      logic [1:0]  v, we, irdy;
      logic        mrdy;
      logic [31:0] mrd;
      logic        emv, emwe;
      logic [1:0]  erdy, einv;
      logic [31:0] eaddr;
      logic        crd;
      logic [31:0] erd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [1:0] irdy, logic mrdy,
                               logic [31:0] mrd, logic emv, logic emwe, logic [1:0] erdy,
                               logic [1:0] einv, logic [31:0] eaddr, logic crd, logic [31:0] erd);
      vec_t r;
      r.v = v; r.we = we; r.irdy = irdy; r.mrdy = mrdy; r.mrd = mrd;
      r.emv = emv; r.emwe = emwe; r.erdy = erdy; r.einv = einv;
      r.eaddr = eaddr; r.crd = crd; r.erd = erd;
      return r;
   endfunction

   task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] irdy,
                        input logic mrdy, input logic [31:0] mrd);
      bus.rw_valid  = v;
      bus.rw_we     = we;
      bus.inv_ready = irdy;
      bus.mem_ready = mrdy;
      bus.mem_rdata = {4{mrd}};
   endtask

   task automatic check_zero(input string nm);
      check({nm, ".mem_valid"}, WIDTH'(bus.mem_valid), '0);
      check({nm, ".mem_addr"},  WIDTH'(bus.mem_addr),  '0);
      check({nm, ".mem_we"},    WIDTH'(bus.mem_we),    '0);
      check({nm, ".mem_wmask"}, WIDTH'(bus.mem_wmask), '0);
      check({nm, ".mem_wdata"}, bus.mem_wdata,         '0);
      check({nm, ".mem_ce"},    WIDTH'(bus.mem_ce),    '0);
      check({nm, ".rw_ready"},  WIDTH'(bus.rw_ready),  '0);
      check({nm, ".r_data"},    bus.r_data,            '0);
      check({nm, ".inv_valid"}, WIDTH'(bus.inv_valid), '0);
      check({nm, ".inv_addr"},  WIDTH'(bus.inv_addr),  '0);
   endtask

   task automatic check_mem(input string nm, input logic we, input logic [AW-1:0] a);
      check({nm, ".mem_valid"}, WIDTH'(bus.mem_valid), WIDTH'(1'b1));
      check({nm, ".mem_addr"},  WIDTH'(bus.mem_addr),  WIDTH'(a));
      check({nm, ".mem_we"},    WIDTH'(bus.mem_we),    WIDTH'(we));
      check({nm, ".mem_ce"},    WIDTH'(bus.mem_ce),    WIDTH'(1'b1));
      if (we) begin
         check({nm, ".mem_wmask"}, WIDTH'(bus.mem_wmask), WIDTH'((a == A1) ? M1 : M0));
         check({nm, ".mem_wdata"}, bus.mem_wdata, (a == A1) ? D1 : D0);
      end
   endtask

   initial begin
      bus.rw_addr = {A1, A0};
      bus.w_mask  = {M1, M0};
      bus.w_data  = {D1, D0};
      bus.w_ce    = 2'b11;
      drive(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

      //    v      we     irdy   mr    mrd           mv    mwe   rdy    inv    addr  crd   rd
      // read at 3-cycle memory latency
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, A0,    1'b0, 32'h0));
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, A0,    1'b0, 32'h0));
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2'b00, 2'b00, A0,    1'b0, 32'h0));
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 1'b1, 32'hDEADBEEF));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      // port1 write, then independent invalidate acks
      vq.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, A1,    1'b0, 32'h0));
      vq.push_back(mk(2'b10, 2'b10, 2'b00, 1'b1, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, A1,    1'b0, 32'h0));
      vq.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b10, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b11, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b10, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b10, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b10, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b00, 2'b00, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      // both ports keep reading: 0,1,0,1
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 32'h11111111, 1'b1, 1'b0, 2'b00, 2'b00, A0,    1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 1'b1, 32'h11111111));
      vq.push_back(mk(2'b10, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 32'h22222222, 1'b1, 1'b0, 2'b00, 2'b00, A1,    1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b10, 2'b00, 32'h0, 1'b1, 32'h22222222));
      vq.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 32'h33333333, 1'b1, 1'b0, 2'b00, 2'b00, A0,    1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 1'b1, 32'h33333333));
      vq.push_back(mk(2'b10, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 32'h44444444, 1'b1, 1'b0, 2'b00, 2'b00, A1,    1'b0, 32'h0));
      vq.push_back(mk(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b10, 2'b00, 32'h0, 1'b1, 32'h44444444));
      vq.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0));

      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;

      foreach (vq[n]) begin
         tick();
         drive(vq[n].v, vq[n].we, vq[n].irdy, vq[n].mrdy, vq[n].mrd);
         check($sformatf("vec%0d.mem_valid", n), WIDTH'(bus.mem_valid), WIDTH'(vq[n].emv));
         check($sformatf("vec%0d.rw_ready", n),  WIDTH'(bus.rw_ready),  WIDTH'(vq[n].erdy));
         check($sformatf("vec%0d.inv_valid", n), WIDTH'(bus.inv_valid), WIDTH'(vq[n].einv));
         if (vq[n].emv) check_mem($sformatf("vec%0d", n), vq[n].emwe, vq[n].eaddr);
         if (vq[n].crd) check($sformatf("vec%0d.r_data", n), bus.r_data, {4{vq[n].erd}});
         if (vq[n].einv != 2'b00) check($sformatf("vec%0d.inv_addr", n), WIDTH'(bus.inv_addr), WIDTH'(A1));
      end

      // port0 write completes while port1 has a read queued; port1 defers its ack past the read
      tick();
      drive(2'b11, 2'b01, 2'b00, 1'b0, 32'h0);
      check("dl.idle.mem_valid", WIDTH'(bus.mem_valid), '0);
      tick();
      check_mem("dl.wr", 1'b1, A0);
      drive(2'b11, 2'b01, 2'b00, 1'b1, 32'h0);
      tick();
      drive(2'b11, 2'b01, 2'b00, 1'b0, 32'h0);
      check("dl.wr.rw_ready", WIDTH'(bus.rw_ready), WIDTH'(2'b01));
      check("dl.wr.inv_valid", WIDTH'(bus.inv_valid), '0);
      tick();
      drive(2'b10, 2'b00, 2'b00, 1'b0, 32'h0);
      check("dl.post.inv_valid", WIDTH'(bus.inv_valid), WIDTH'(2'b11));
      check("dl.post.inv_addr", WIDTH'(bus.inv_addr), WIDTH'(A0));
      check("dl.post.rw_ready", WIDTH'(bus.rw_ready), '0);
      tick();
      check_mem("dl.rd", 1'b0, A1);
      check("dl.rd.inv_valid", WIDTH'(bus.inv_valid), WIDTH'(2'b11));
      drive(2'b10, 2'b00, 2'b01, 1'b1, 32'hCAFE0001);
      tick();
      drive(2'b10, 2'b00, 2'b00, 1'b0, 32'h0);
      check("dl.rd.rw_ready", WIDTH'(bus.rw_ready), WIDTH'(2'b10));
      check("dl.rd.r_data", bus.r_data, {4{32'hCAFE0001}});
      check("dl.rd.inv_valid", WIDTH'(bus.inv_valid), WIDTH'(2'b10));

      // second port0 write must wait for port1's ack
      tick();
      drive(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
      check("st.inv_valid", WIDTH'(bus.inv_valid), WIDTH'(2'b10));
      for (int s = 0; s < 3; s++) begin
         tick();
         check($sformatf("st.hold%0d.mem_valid", s), WIDTH'(bus.mem_valid), '0);
         check($sformatf("st.hold%0d.inv_valid", s), WIDTH'(bus.inv_valid), WIDTH'(2'b10));
      end
      drive(2'b01, 2'b01, 2'b10, 1'b0, 32'h0);
      tick();
      drive(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
      check("st.ack.inv_valid", WIDTH'(bus.inv_valid), '0);
      check("st.ack.mem_valid", WIDTH'(bus.mem_valid), '0);
      tick();
      check_mem("st.wr", 1'b1, A0);
      drive(2'b01, 2'b01, 2'b00, 1'b1, 32'h0);
      tick();
      drive(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
      check("st.wr.rw_ready", WIDTH'(bus.rw_ready), WIDTH'(2'b01));
      tick();
      drive(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);
      check("st.post.inv_valid", WIDTH'(bus.inv_valid), WIDTH'(2'b11));

      // reset while invalidates are pending
      rst = 1'b1;
      tick();
      check_zero("rst_inv");
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         check($sformatf("rst_inv.q%0d.inv_valid", s), WIDTH'(bus.inv_valid), '0);
         check($sformatf("rst_inv.q%0d.rw_ready", s), WIDTH'(bus.rw_ready), '0);
      end

      // reset while a read is in MEM
      drive(2'b10, 2'b00, 2'b00, 1'b0, 32'h0);
      tick();
      check_mem("rst_mem.rd", 1'b0, A1);
      drive(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      check_zero("rst_mem");
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         drive(2'b00, 2'b00, 2'b00, 1'b1, 32'hFFFFFFFF);
         check($sformatf("rst_mem.q%0d.rw_ready", s), WIDTH'(bus.rw_ready), '0);
         check($sformatf("rst_mem.q%0d.mem_valid", s), WIDTH'(bus.mem_valid), '0);
         check($sformatf("rst_mem.q%0d.inv_valid", s), WIDTH'(bus.inv_valid), '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/snoopy_bus_ctrl.md
Name: snoopy_bus_ctrl

Overview:
Responder end of the SystemBus: services read/write requests from NPORT snoopy read-only caches, forwards them one at a time to a single memory port, and returns read data. After every completed write it broadcasts a snoop invalidation to all ports, including the writer, because a read-only cache does not update its own line on a write-through. It sits between the per-core caches and the memory and peripheral side.

Parameters:
NPORT, 2, number of SystemBus user ports.
WIDTH, 128, data line width in bits.
MASKW, WIDTH/8, byte-mask width.
ADDR_WIDTH, 32, address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rw_valid  in  NPORT  per-port request valid; held until rw_ready
rw_ready  out  NPORT  per-port one-cycle completion pulse
rw_addr  in  NPORT*ADDR_WIDTH  per-port address; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
rw_we  in  NPORT  per-port write flag
w_mask  in  NPORT*MASKW  per-port byte mask
w_data  in  NPORT*WIDTH  per-port write data
w_ce  in  NPORT  per-port write chip-enable; forwarded to memory
r_data  out  WIDTH  read data; valid in the rw_ready cycle of the granted port
inv_valid  out  NPORT  per-port invalidate request; level, held until acked
inv_addr  out  ADDR_WIDTH  invalidate address, shared by all ports
inv_ready  in  NPORT  per-port invalidate ack pulse
mem_valid  out  1  memory request
mem_ready  in  1  memory completion pulse; mem_rdata valid in the same cycle
mem_addr  out  ADDR_WIDTH  memory address
mem_we  out  1  memory write
mem_wmask  out  MASKW  memory byte mask
mem_wdata  out  WIDTH  memory write data
mem_ce  out  1  memory chip-enable
mem_rdata  in  WIDTH  memory read data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, grant 0, inv_pend 0, inv_addr 0, round-robin pointer 0.
- Reset mid-operation abandons any transaction. No rw_ready or inv_valid is issued after reset.
- FSM states: IDLE, MEM, RESP.
- IDLE: a port is eligible if rw_valid[i]=1 and (rw_we[i]=0 or inv_pend==0).
  - Pick one eligible port (arbitration below).
  - Latch grant, addr, we, mask, data and ce from that port, then go to MEM.
  - With no eligible port, stay in IDLE.
- MEM: drive mem_valid=1 and mem_* from the latched values, stable until mem_ready.
  - On mem_ready, latch mem_rdata into the r_data register and go to RESP.
  - mem_valid drops in the cycle after mem_ready.
- RESP: rw_ready[grant]=1 for exactly one cycle, with r_data held from the latch. Then go to IDLE.
  - If the transaction was a write: set inv_pend[all NPORT]=1 and inv_addr=latched addr at the RESP edge.
- Latency: request seen in IDLE cycle t; mem_valid from t+1; mem_ready at cycle m; rw_ready at m+1.
- After its rw_ready, the granted port is not re-granted in the following IDLE cycle: its caller has already dropped rw_valid.
- Invalidations are posted:
  - inv_valid[i]=inv_pend[i].
  - inv_pend[i] clears on the edge where inv_ready[i]=1.
  - inv_addr is constant while any inv_pend bit is set.
  - inv_ready[i] with inv_pend[i]=0 is ignored.
- Reads are granted while invalidations are outstanding. This is mandatory:
  - A cache in refill defers its invalidate ack until the refill completes, so blocking reads would deadlock.
  - The refill returns post-write memory data, so it is never stale.
- A new write is held off until inv_pend==0, so set and clear of inv_pend never coincide.
- Ordering: the writer's rw_ready can precede the other ports' invalidate acks (weak snoop ordering, by design).
- Arbitration, default (fixed priority): the lowest-index eligible port wins.
- All unselected rw_ready bits are 0 in every cycle.

Optional Feature:
SYSBUS_RR_ARB_EN:
- Defined: round-robin arbitration. The pointer advances to grant+1 (mod NPORT) at each RESP, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins, pointer logic absent.
- The handshake is unchanged in both cases.

Test Plan:
- Read: port0 reads 0x1000, memory returns 0xDEAD_BEEF at 3-cycle latency -> mem_valid for 3 cycles; rw_ready[0] pulses once, 1 cycle after mem_ready, with r_data=0xDEAD_BEEF; no inv_valid.
- Write: port1 writes 0x2000, mask 0x000F -> mem_we=1 and mem_wmask=0x000F; rw_ready[1] pulse; then inv_valid=2'b11 with inv_addr=0x2000; each bit clears on its own inv_ready, acks sent 2 and 5 cycles later.
- Deadlock avoidance: port0 write completes while port1 has a read pending; port1 withholds inv_ready until its read finishes -> port1 read is granted and completes; then port1 acks and inv_pend returns to 0.
- Write stall: port0 issues a second write while inv_pend=2'b10 -> no mem_valid until inv_ready[1]; granted the next IDLE cycle.
- Arbitration: both ports request reads every cycle -> default build serves port0 first; with SYSBUS_RR_ARB_EN the ports alternate 0,1,0,1.
- Reset mid-op: assert rst during MEM and during inv pending -> the next cycle has all outputs 0; no rw_ready or inv_valid appears afterwards until a new request.
